cbc_stream_cipher: RTL
======================

CBC_STREAM_CIPHER -- requirements
Module: cbc_stream_cipher

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 32: key, IV and block width in bits.
REQ-002 SHALL have parameter HSIZE, default 768: image row width in bits; must be an integer multiple of BLOCK_SIZE.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: request valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept a row.
REQ-007 SHALL have port decrypt, input, 1: 0 = encrypt, 1 = decrypt.
REQ-008 SHALL have port cbc, input, 1: 0 = ECB, 1 = CBC.
REQ-009 SHALL have port key, input, BLOCK_SIZE: cipher key.
REQ-010 SHALL have port iv, input, BLOCK_SIZE: CBC initial chain value.
REQ-011 SHALL have port row_in, input, HSIZE: plaintext row (encrypt) or ciphertext row (decrypt).
REQ-012 SHALL have port out_valid, output, 1: row_out valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts row_out.
REQ-014 SHALL have port row_out, output, HSIZE: result row.
REQ-015 SHALL have port busy, output, 1: high in RUN or DONE.

Function
REQ-016 SHALL define NBLK = HSIZE/BLOCK_SIZE; block i is row bits [i*BLOCK_SIZE +: BLOCK_SIZE], processed in order i = 0..NBLK-1.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-018 SHALL accept a row on an edge where in_valid and in_ready are both high: latch row_in, key, iv, decrypt and cbc; load chain register with iv; clear block counter; go to RUN.
REQ-019 SHALL, in RUN, process one block per cycle; the counter increments 0..NBLK-1, and after block NBLK-1 the FSM goes to DONE.
REQ-020 SHALL compute in ECB: out_i = in_i XOR key.
REQ-021 SHALL compute in CBC encrypt: out_i = in_i XOR key XOR chain, then chain <= out_i.
REQ-022 SHALL compute in CBC decrypt: out_i = in_i XOR key XOR chain, then chain <= in_i.
REQ-023 SHALL assert out_valid in DONE only, first asserted NBLK+1 edges after the accept edge.
REQ-024 SHALL hold row_out stable while out_valid=1 and out_ready=0.
REQ-025 SHALL return DONE -> IDLE on an edge with out_ready=1; in_ready rises the following cycle (one-cycle bubble).
REQ-026 SHALL ignore in_valid and input changes outside IDLE; latched operands are unaffected by them.
REQ-027 SHALL ignore out_ready outside DONE.
REQ-028 SHALL make row_out a registered output, updated only by RUN block writes.
REQ-029 SHALL use a counter of width max(1, clog2(NBLK)), with no wrap beyond NBLK-1.

Reset
REQ-030 SHALL, while rst_n=0, force FSM=IDLE, counter=0, chain=0, row_out=0, out_valid=0, busy=0 and in_ready=1 (in_ready=1 follows from IDLE).
REQ-031 SHALL, on reset assertion in RUN or DONE, abort the row immediately and leave no pending output after release.
REQ-032 SHALL permit acceptance on the first rising edge after rst_n deasserts.

Configuration
REQ-033 SHALL, when macro CBC_STREAM_CBC_EN is defined, honour the cbc input per REQ-021 and REQ-022.
REQ-034 SHALL, when CBC_STREAM_CBC_EN is undefined, omit the chain register, iv and cbc logic and always apply ECB; iv and cbc remain ports but are ignored.

Verification
REQ-035 SHALL cover: HSIZE=96, BLOCK_SIZE=32, ECB encrypt, key=0xFFFFFFFF, row_in=0 -> row_out=all ones, out_valid 4 edges after accept.
REQ-036 SHALL cover: CBC encrypt, key=0, iv=0x00000001, row_in=0 -> blocks 0,1,2 = 0x00000001; then CBC decrypt of that result with same key/iv -> row_out=0.
REQ-037 SHALL cover: CBC encrypt, key=0xA5A5A5A5, iv=0x12345678, random row, then CBC decrypt of the result -> original row restored exactly.
REQ-038 SHALL cover: out_ready held low 10 cycles in DONE -> row_out and out_valid stable, in_ready=0, in_valid pulses ignored; after out_ready=1 -> IDLE next cycle.
REQ-039 SHALL cover: rst_n pulsed low during RUN block 1 -> out_valid=0 and row_out=0 immediately; a new row accepted after release is processed correctly.
REQ-040 SHALL cover: build without CBC_STREAM_CBC_EN, cbc=1, key=0, iv=0xFFFFFFFF, row_in=0 -> row_out=0 (ECB applied).

Source files
------------

// File: rtl/cbc_stream_cipher.sv
// Row-at-a-time XOR block cipher, one BLOCK_SIZE block per cycle, ECB or CBC chaining.
// Define CBC_STREAM_CBC_EN to build the CBC chain; otherwise only ECB is implemented and iv/cbc are ignored.
module cbc_stream_cipher #(
  parameter int BLOCK_SIZE = 32,
  parameter int HSIZE      = 768
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  decrypt,
  input  logic                  cbc,
  input  logic [BLOCK_SIZE-1:0] key,
  input  logic [BLOCK_SIZE-1:0] iv,
  input  logic [HSIZE-1:0]      row_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HSIZE-1:0]      row_out,
  output logic                  busy
);

  localparam int NBLK = HSIZE / BLOCK_SIZE;
  localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBLK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [HSIZE-1:0]        row_reg;
  logic [BLOCK_SIZE-1:0]   key_reg;
  logic [CW-1:0]           cnt;
  logic [BLOCK_SIZE-1:0]   blk_in;
  logic [BLOCK_SIZE-1:0]   blk_out;

`ifdef CBC_STREAM_CBC_EN
  logic [BLOCK_SIZE-1:0]   chain;
  logic                    dec_reg;
  logic                    cbc_reg;
`else
  logic                    unused_inputs;
  assign unused_inputs = ^{iv, cbc, decrypt};
`endif

  always_comb begin
    blk_in  = row_reg[cnt*BLOCK_SIZE +: BLOCK_SIZE];
    blk_out = blk_in ^ key_reg;
`ifdef CBC_STREAM_CBC_EN
    if (cbc_reg) blk_out = blk_out ^ chain;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      row_reg   <= '0;
      key_reg   <= '0;
      row_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
`ifdef CBC_STREAM_CBC_EN
      chain     <= '0;
      dec_reg   <= 1'b0;
      cbc_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            row_reg  <= row_in;
            key_reg  <= key;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef CBC_STREAM_CBC_EN
            chain    <= iv;
            dec_reg  <= decrypt;
            cbc_reg  <= cbc;
`endif
          end
        end
        RUN: begin
          row_out[cnt*BLOCK_SIZE +: BLOCK_SIZE] <= blk_out;
`ifdef CBC_STREAM_CBC_EN
          chain <= dec_reg ? blk_in : blk_out;
`endif
          if (cnt == LAST) state <= DONE;
          else             cnt   <= cnt + 1'b1;
        end
        DONE: begin
          // out_valid rises one cycle after DONE entry; exit waits for it so a row is never dropped unseen
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
